// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 16 x 16-bit register file.
// Two writeback sources share one write port: requester 0 is ALU writeback and
// requester 1 is load writeback. After reset, and on clear_req, the block sweeps
// registers 1..2^REGBITS-1 to zero before it accepts any request.
// Accepted writes reach regwrite/wa/wd one clock after the handshake.
module regfile_wr_arbiter #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_req,
    input  logic               req0_valid,
    input  logic [REGBITS-1:0] req0_addr,
    input  logic [WIDTH-1:0]   req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [REGBITS-1:0] req1_addr,
    input  logic [WIDTH-1:0]   req1_data,
    output logic               req1_ready,
    output logic               clear_busy,
    output logic               regwrite,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd
);

    localparam logic [REGBITS-1:0] LAST_ADDR = {REGBITS{1'b1}};
    localparam logic [REGBITS-1:0] ONE_ADDR  = {{(REGBITS-1){1'b0}}, 1'b1};

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [REGBITS-1:0] counter, counter_next;
    logic               last_grant, last_grant_next;

    // State register; reset starts a fresh sweep at register 1 and favours requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR;
            counter    <= ONE_ADDR;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            last_grant <= last_grant_next;
        end
    end

    // Next-state logic: the sweep runs to the top address; clear_req in RUN restarts it.
    always_comb begin
        state_next      = state;
        counter_next    = counter;
        last_grant_next = last_grant;
        case (state)
            CLEAR: begin
                counter_next = counter + ONE_ADDR;
                if (counter == LAST_ADDR) begin
                    state_next   = RUN;
                    counter_next = ONE_ADDR;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_next   = CLEAR;
                    counter_next = ONE_ADDR;
                end else if (req0_ready) begin
                    last_grant_next = 1'b0;
                end else if (req1_ready) begin
                    last_grant_next = 1'b1;
                end
            end
            default: begin
                state_next   = CLEAR;
                counter_next = ONE_ADDR;
            end
        endcase
    end

    // Handshake outputs: round-robin on ties, nothing granted while sweeping or clearing.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        clear_busy = (state == CLEAR);
        if (state == RUN && !clear_req) begin
            req0_ready = req0_valid && (!req1_valid || last_grant);
            req1_ready = req1_valid && (!req0_valid || !last_grant);
        end
    end

    // Registered write port: sweep writes zeros, accepted requests write one cycle later,
    // writes to register 0 are swallowed and wa/wd hold when nothing is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite <= 1'b0;
            wa       <= '0;
            wd       <= '0;
        end else if (state == CLEAR) begin
            regwrite <= 1'b1;
            wa       <= counter;
            wd       <= '0;
        end else if (req0_ready) begin
            regwrite <= (req0_addr != '0);
            if (req0_addr != '0) begin
                wa <= req0_addr;
                wd <= req0_data;
            end
        end else if (req1_ready) begin
            regwrite <= (req1_addr != '0);
            if (req1_addr != '0) begin
                wa <= req1_addr;
                wd <= req1_data;
            end
        end else begin
            regwrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: stimulus pushes hand-computed expected
// register writes into a queue, a negedge monitor pops one per observed regwrite.
module tb_regfile_wr_arbiter;

    localparam int WIDTH   = 16;
    localparam int REGBITS = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               clear_req = 1'b0;
    logic               req0_valid = 1'b0;
    logic [REGBITS-1:0] req0_addr = '0;
    logic [WIDTH-1:0]   req0_data = '0;
    logic               req0_ready;
    logic               req1_valid = 1'b0;
    logic [REGBITS-1:0] req1_addr = '0;
    logic [WIDTH-1:0]   req1_data = '0;
    logic               req1_ready;
    logic               clear_busy;
    logic               regwrite;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;

    typedef struct packed {
        logic [REGBITS-1:0] a;
        logic [WIDTH-1:0]   d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  passes = 0;

    regfile_wr_arbiter #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clear_busy (clear_busy),
        .regwrite   (regwrite),
        .wa         (wa),
        .wd         (wd)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b1 && regwrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_write: got wa=%0d wd=%0h expected no write", wa, wd);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("mon_wa", 32'(wa), 32'(mon_e.a));
                checkOutput("mon_wd", 32'(wd), 32'(mon_e.d));
            end
        end
    end

    // One cycle of stimulus: drive after the edge, check readies/busy mid-cycle,
    // queue the writes the bench expects this cycle's transfer to produce.
    task automatic applyStimulus(
        input logic v0, input logic [REGBITS-1:0] a0, input logic [WIDTH-1:0] d0,
        input logic v1, input logic [REGBITS-1:0] a1, input logic [WIDTH-1:0] d1,
        input logic clr, input logic er0, input logic er1, input logic ebusy,
        input string tag);
        #1;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        clear_req  = clr;
        @(negedge clk);
        checkOutput({tag, ".req0_ready"}, 32'(req0_ready), 32'(er0));
        checkOutput({tag, ".req1_ready"}, 32'(req1_ready), 32'(er1));
        checkOutput({tag, ".clear_busy"}, 32'(clear_busy), 32'(ebusy));
        if (er0 && a0 != '0) exp_q.push_back('{a: a0, d: d0});
        if (er1 && a1 != '0) exp_q.push_back('{a: a1, d: d1});
        @(posedge clk);
    endtask

    task automatic pushSweep();
        for (int i = 1; i < (1 << REGBITS); i++)
            exp_q.push_back('{a: REGBITS'(i), d: '0});
    endtask

    task automatic runSweep(input int n, input int clr_at);
        for (int k = 1; k <= n; k++)
            applyStimulus(1'b1, 4'd6, 16'h1111, 1'b1, 4'd7, 16'h2222,
                          (k == clr_at), 1'b0, 1'b0, 1'b1, "sweep");
    endtask

    initial begin
        $display("[TB] start");
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        checkOutput("rst.regwrite",   32'(regwrite),   32'd0);
        checkOutput("rst.wa",         32'(wa),         32'd0);
        checkOutput("rst.wd",         32'(wd),         32'd0);
        checkOutput("rst.clear_busy", 32'(clear_busy), 32'd1);
        checkOutput("rst.req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("rst.req1_ready", 32'(req1_ready), 32'd0);

        // Power-up sweep with both requesters pushing.
        @(posedge clk);
        #1 reset = 1'b1;
        pushSweep();
        runSweep(15, 0);

        // Contention: strict alternation starting with requester 0.
        applyStimulus(1, 4'd2, 16'h0002, 1, 4'd5, 16'h0005, 0, 1, 0, 0, "tie1");
        applyStimulus(1, 4'd2, 16'h0002, 1, 4'd5, 16'h0005, 0, 0, 1, 0, "tie2");
        applyStimulus(1, 4'd2, 16'h0002, 1, 4'd5, 16'h0005, 0, 1, 0, 0, "tie3");
        applyStimulus(1, 4'd2, 16'h0002, 1, 4'd5, 16'h0005, 0, 0, 1, 0, "tie4");

        // Single requester, then idle cycles.
        applyStimulus(1, 4'd3, 16'hBEEF, 0, 4'd0, 16'h0000, 0, 1, 0, 0, "single");
        applyStimulus(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 0, 0, "idle1");
        applyStimulus(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 0, 0, "idle2");

        // Address-0 write is accepted and dropped; last_grant moves to 1.
        applyStimulus(0, 4'd0, 16'h0000, 1, 4'd0, 16'hFFFF, 0, 0, 1, 0, "addr0");
        applyStimulus(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 0, 0, "idle3");
        applyStimulus(1, 4'd2, 16'h0022, 1, 4'd5, 16'h0055, 0, 1, 0, 0, "tie_after0");
        applyStimulus(0, 4'd2, 16'h0022, 1, 4'd5, 16'h0055, 0, 0, 1, 0, "tie_after1");
        applyStimulus(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 0, 0, "idle4");

        // clear_req in RUN blocks the request; a second clear_req mid-sweep is ignored.
        applyStimulus(1, 4'd4, 16'h0044, 0, 4'd0, 16'h0000, 1, 0, 0, 0, "clear");
        pushSweep();
        runSweep(15, 5);
        applyStimulus(1, 4'd9, 16'h0099, 0, 4'd0, 16'h0000, 0, 1, 0, 0, "post_sweep");
        applyStimulus(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 0, 0, "idle5");

        // Async reset partway through a sweep, after the wa=7 write is visible.
        applyStimulus(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 0, 0, "clear2");
        pushSweep();
        runSweep(7, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("arst.regwrite",   32'(regwrite),   32'd0);
        checkOutput("arst.wa",         32'(wa),         32'd0);
        checkOutput("arst.clear_busy", 32'(clear_busy), 32'd1);
        checkOutput("arst.req0_ready", 32'(req0_ready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        pushSweep();
        runSweep(15, 0);
        applyStimulus(1, 4'd8, 16'h0088, 0, 4'd0, 16'h0000, 0, 1, 0, 0, "post_reset");
        applyStimulus(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 0, 0, "idle6");
        applyStimulus(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 0, 0, "idle7");

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single write port of the processor's register file (16 x 16-bit, register 0 hardwired to 0) between two writeback requesters. Requester 0 is ALU writeback and requester 1 is memory-load writeback. After reset, and on request, the block first sweeps registers 1..(2^REGBITS-1) to zero so no register holds an X value. It sits between the datapath writeback sources and the regfile's regwrite/wa/wd inputs.

Parameters:
WIDTH, 16, data width of the register file.
REGBITS, 4, address width; the register file has 2^REGBITS entries.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous reset, active-low (asserted at 0).
clear_req  in  1  synchronous pulse that restarts the zero-sweep; honoured only in RUN.
req0_valid  in  1  ALU writeback request.
req0_addr  in  REGBITS  ALU destination register.
req0_data  in  WIDTH  ALU result.
req0_ready  out  1  request 0 accepted this cycle.
req1_valid  in  1  load writeback request.
req1_addr  in  REGBITS  load destination register.
req1_data  in  WIDTH  load data.
req1_ready  out  1  request 1 accepted this cycle.
clear_busy  out  1  high while the zero-sweep is in progress.
regwrite  out  1  to regfile regwrite.
wa  out  REGBITS  to regfile wa.
wd  out  WIDTH  to regfile wd.

Behaviour:
- Reset (reset=0, async) values:
  - State CLEAR, sweep counter=1, last_grant=1 (so requester 0 wins the first tie).
  - regwrite=0, wa=0, wd=0, clear_busy=1, req0_ready=0, req1_ready=0.
- The reset level is held internally; all state changes occur only on rising clk edges after reset deasserts.
- States: CLEAR and RUN.
- CLEAR:
  - Each cycle, register regwrite=1, wa=counter, wd=0, then increment counter.
  - Address 0 is never written.
  - After the write to address 2^REGBITS-1, go to RUN and drop clear_busy on the same edge that issues that final write.
  - The sweep takes exactly 2^REGBITS-1 cycles (15 at default).
  - req*_ready is held 0 throughout; requests are ignored, not queued.
- RUN handshake: a request transfers in any cycle where valid=1 and ready=1. ready is combinational from the current valid inputs and state.
  - Only req0 valid: req0_ready=1.
  - Only req1 valid: req1_ready=1.
  - Both valid: grant the requester not equal to last_grant, then update last_grant to the winner. This is strict round-robin.
  - At most one ready is high per cycle.
  - last_grant updates only on a transfer.
- Output timing:
  - The accepted request drives regwrite=1, wa=addr, wd=data on the next rising edge, so the regfile writes one cycle after acceptance (latency 1).
  - In cycles with no transfer, the next edge sets regwrite=0; wa and wd hold their previous values.
- Address-0 write: the handshake completes (ready=1), but the registered regwrite is 0. The write is dropped and last_grant still updates.
- Requester contract: must hold valid, addr and data stable until ready. The arbiter does not check this.
- clear_req:
  - Sampled high in RUN: no request is accepted that cycle (both readies 0).
  - Next state is CLEAR with counter=1 and clear_busy=1.
  - A write accepted in the previous cycle still completes on this edge.
  - clear_req in CLEAR is ignored; the sweep does not restart.
- Reset mid-sweep or mid-transfer: all outputs return to their reset values immediately. A pending registered write is lost; the sweep restarts from 1 after reset release.

Test Plan:
- Power-up sweep: release reset -> 15 consecutive cycles of regwrite=1 with wa=1,2,...,15 and wd=0. clear_busy falls after the wa=15 write; both readies are 0 throughout even with both valids held at 1.
- Single requester: in RUN, req0_valid=1, addr=3, data=16'hBEEF for one cycle -> req0_ready=1 that cycle; next cycle regwrite=1, wa=3, wd=16'hBEEF; the cycle after, regwrite=0.
- Contention: both valid for 4 cycles (req0: addr 2/16'h0002; req1: addr 5/16'h0005, each held until accepted then re-presented) -> grants alternate 0,1,0,1; at most one ready per cycle; wa sequence 2,5,2,5.
- Address-0 drop: req1_valid=1, addr=0, data=16'hFFFF -> req1_ready=1; the following cycle regwrite=0. A subsequent tie then grants req0.
- clear_req in RUN with req0 valid -> req0_ready=0 that cycle, clear_busy=1 next cycle, and a full 15-write sweep follows. A second clear_req mid-sweep does not restart it: total sweep is still 15 cycles.
- Async reset mid-sweep (at wa=7): reset=0 between edges -> regwrite=0 and clear_busy=1 immediately, without waiting for a clock edge. After release, the sweep restarts at wa=1.
